lbdr_route_compute_scheduler: RTL and testbench
===============================================

// Module: lbdr_route_compute_scheduler
// PURPOSE
//  Time-shares one LBDR route-computation unit among the router's input VCs.
//  Arbitrates pending head-flit route requests round-robin and drives the winner's destination to the shared LBDR unit.
//  Captures the candidate output-port vector and selects one output port, preferring ports with downstream credit.
//  Holds the result until the VC allocator accepts it. Sits between the input-buffer stage and VC allocation.
// PARAMETERS
//  NumberOfRequesters  5   input VCs/ports sharing the LBDR unit (>=2)
//  DimensionXWidth     2   bits of X coordinate
//  DimensionYWidth     2   bits of Y coordinate
//  NumberOfPorts       5   router ports; indices follow `LBDR_2D_PORT_DIRECTION_INDEX_* macros
//  RequesterIdWidth    num_bits(NumberOfRequesters-1)  width of requester index
// PORTS
//  clk_i               in   1                      clock
//  rst_ni              in   1                      reset, asynchronous, active-low
//  req_valid_i         in   NumberOfRequesters     per-requester route request pending
//  req_x_dst_i         in   NumberOfRequesters*DX  dst X per requester, requester r at [r*DX +: DX]
//  req_y_dst_i         in   NumberOfRequesters*DY  dst Y per requester, same packing
//  req_ready_o         out  NumberOfRequesters     one-hot acceptance pulse
//  rc_x_dst_o          out  DX                     dst X to shared LBDR unit
//  rc_y_dst_o          out  DY                     dst Y to shared LBDR unit
//  rc_valid_ports_i    in   NumberOfPorts          candidate ports returned by LBDR unit (combinational)
//  port_avail_i        in   NumberOfPorts          downstream credit available per output port
//  resp_valid_o        out  1                      routing result valid
//  resp_ready_i        in   1                      allocator accepts result
//  resp_req_id_o       out  RequesterIdWidth       requester owning the result
//  resp_port_o         out  NumberOfPorts          selected output port, one-hot
//  resp_candidates_o   out  NumberOfPorts          full captured candidate vector
//  unroutable_o        out  1                      sticky: a request produced no candidate
// BEHAVIOUR
//  Reset: FSM=IDLE; rr pointer=0; all outputs 0 (req_ready_o, resp_*, rc_*_dst_o, unroutable_o).
//  FSM IDLE: if |req_valid_i, grant the first valid requester at or after rr pointer (wrapping).
//    req_ready_o[g]=1 for exactly that cycle. Latch g and its dst into registers. Go to COMPUTE.
//  FSM COMPUTE (1 cycle): rc_*_dst_o driven from latched dst (registered, stable all COMPUTE+RESP).
//    Capture rc_valid_ports_i into resp_candidates_o.
//    If candidates==0: set unroutable_o, drop the request, rr pointer=g+1 mod N, go to IDLE.
//    Else: sel = first port of (candidates & port_avail_i) by rotating preference starting at sel_ptr.
//      If that set is empty, sel = first port of candidates by the same rotation.
//      Go to RESP.
//  FSM RESP: resp_valid_o=1; resp_port_o, resp_req_id_o and resp_candidates_o held stable.
//    On resp_valid_o & resp_ready_i: resp_valid_o=0 next cycle; rr pointer=g+1 mod N; sel_ptr=sel_index+1 mod NumberOfPorts; go to IDLE.
//  Latency: accept at cycle T; resp_valid_o asserts at T+2 minimum. Throughput: 1 route per 3 cycles when resp_ready_i=1.
//  req_ready_o is 0 in COMPUTE and RESP; requesters hold req_valid_i and dst until their ready pulse.
//  Local-only candidate (dst==cur) is selected regardless of port_avail_i.
//  resp_port_o is always exactly one-hot when resp_valid_o=1, and always a subset of resp_candidates_o.
//  Requester dropping req_valid_i without a grant: permitted; that requester is simply skipped.
//  Reset mid-operation returns immediately to reset state; a pending result is lost (no resp).
//  unroutable_o clears only on reset.
// TESTING
//  Reset then req_valid_i=0 for 10 cycles -> all outputs stay 0, FSM IDLE.
//  Req 2 only, dst with LBDR E candidate, avail all 1 -> ready[2] at T, resp_valid at T+2, resp_port=E, id=2.
//  Req 0,1,3 held, resp_ready_i=1 -> grant order 0,1,3,0 with rr wrap; each ready pulse exactly 1 cycle.
//  Candidates N|E, port_avail E=0 -> resp_port=N. Candidates N|E, avail N=E=0 -> rotation pick, held until ready.
//  resp_ready_i=0 for 8 cycles in RESP -> resp outputs stable, rc_*_dst_o stable, no new req_ready_o pulse.
//  Candidates=0 -> unroutable_o=1 sticky, no resp_valid_o; next request served; rst_ni low mid-RESP clears everything.

Source files
------------

// File: rtl/lbdr_route_compute_scheduler.sv
// Shares one LBDR route-computation unit among the router's input VCs: round-robin request
// arbitration, candidate-port capture, credit-aware output-port selection and result hand-off.
module lbdr_route_compute_scheduler #(
    parameter int NumberOfRequesters = 5,
    parameter int DimensionXWidth    = 2,
    parameter int DimensionYWidth    = 2,
    parameter int NumberOfPorts      = 5,
    parameter int RequesterIdWidth   = (NumberOfRequesters > 1) ? $clog2(NumberOfRequesters) : 1
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  logic [NumberOfRequesters-1:0]                 req_valid_i,
    input  logic [NumberOfRequesters*DimensionXWidth-1:0] req_x_dst_i,
    input  logic [NumberOfRequesters*DimensionYWidth-1:0] req_y_dst_i,
    output logic [NumberOfRequesters-1:0]                 req_ready_o,
    output logic [DimensionXWidth-1:0]                    rc_x_dst_o,
    output logic [DimensionYWidth-1:0]                    rc_y_dst_o,
    input  logic [NumberOfPorts-1:0]                      rc_valid_ports_i,
    input  logic [NumberOfPorts-1:0]                      port_avail_i,
    output logic                                          resp_valid_o,
    input  logic                                          resp_ready_i,
    output logic [RequesterIdWidth-1:0]                   resp_req_id_o,
    output logic [NumberOfPorts-1:0]                      resp_port_o,
    output logic [NumberOfPorts-1:0]                      resp_candidates_o,
    output logic                                          unroutable_o
);

    localparam int PortIdxWidth = (NumberOfPorts > 1) ? $clog2(NumberOfPorts) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_RESP    = 2'd2
    } state_e;

    state_e                      state_q, state_d;
    logic [RequesterIdWidth-1:0] rr_ptr_q, rr_ptr_d;
    logic [PortIdxWidth-1:0]     sel_ptr_q, sel_ptr_d;
    logic [RequesterIdWidth-1:0] gnt_id_q, gnt_id_d;
    logic [DimensionXWidth-1:0]  x_dst_q, x_dst_d;
    logic [DimensionYWidth-1:0]  y_dst_q, y_dst_d;
    logic [NumberOfPorts-1:0]    cand_q, cand_d;
    logic [NumberOfPorts-1:0]    port_q, port_d;
    logic [PortIdxWidth-1:0]     sel_idx_q, sel_idx_d;
    logic                        unroutable_q, unroutable_d;

    logic                        arb_found;
    logic [RequesterIdWidth-1:0] arb_idx;
    logic [NumberOfPorts-1:0]    eligible;
    logic [PortIdxWidth-1:0]     sel_pick;

    // First set requester scanning upward from start and wrapping around.
    function automatic logic [RequesterIdWidth-1:0] first_requester(
        input logic [NumberOfRequesters-1:0] vec,
        input logic [RequesterIdWidth-1:0]   start
    );
        logic [RequesterIdWidth-1:0] first;
        logic                        found;
        first = '0;
        found = 1'b0;
        for (int k = 0; k < NumberOfRequesters; k++) begin
            for (int j = 0; j < NumberOfRequesters; j++) begin
                if (!found && vec[j] && (j == (int'(start) + k) % NumberOfRequesters)) begin
                    found = 1'b1;
                    first = RequesterIdWidth'(j);
                end
            end
        end
        return first;
    endfunction

    function automatic logic [PortIdxWidth-1:0] first_port(
        input logic [NumberOfPorts-1:0] vec,
        input logic [PortIdxWidth-1:0]  start
    );
        logic [PortIdxWidth-1:0] first;
        logic                    found;
        first = '0;
        found = 1'b0;
        for (int k = 0; k < NumberOfPorts; k++) begin
            for (int j = 0; j < NumberOfPorts; j++) begin
                if (!found && vec[j] && (j == (int'(start) + k) % NumberOfPorts)) begin
                    found = 1'b1;
                    first = PortIdxWidth'(j);
                end
            end
        end
        return first;
    endfunction

    function automatic logic [RequesterIdWidth-1:0] next_requester(
        input logic [RequesterIdWidth-1:0] id
    );
        return (int'(id) == NumberOfRequesters - 1) ? '0 : id + RequesterIdWidth'(1);
    endfunction

    function automatic logic [PortIdxWidth-1:0] next_port(input logic [PortIdxWidth-1:0] idx);
        return (int'(idx) == NumberOfPorts - 1) ? '0 : idx + PortIdxWidth'(1);
    endfunction

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        sel_ptr_d    = sel_ptr_q;
        gnt_id_d     = gnt_id_q;
        x_dst_d      = x_dst_q;
        y_dst_d      = y_dst_q;
        cand_d       = cand_q;
        port_d       = port_q;
        sel_idx_d    = sel_idx_q;
        unroutable_d = unroutable_q;
        req_ready_o  = '0;

        arb_found = |req_valid_i;
        arb_idx   = first_requester(req_valid_i, rr_ptr_q);

        // Prefer candidates with downstream credit; fall back to any candidate so a
        // local-only or fully congested route still resolves to one port.
        eligible = rc_valid_ports_i & port_avail_i;
        sel_pick = (|eligible) ? first_port(eligible, sel_ptr_q)
                               : first_port(rc_valid_ports_i, sel_ptr_q);

        case (state_q)
            ST_IDLE: begin
                if (arb_found) begin
                    for (int r = 0; r < NumberOfRequesters; r++) begin
                        req_ready_o[r] = (arb_idx == RequesterIdWidth'(r));
                        if (arb_idx == RequesterIdWidth'(r)) begin
                            x_dst_d = req_x_dst_i[r*DimensionXWidth +: DimensionXWidth];
                            y_dst_d = req_y_dst_i[r*DimensionYWidth +: DimensionYWidth];
                        end
                    end
                    gnt_id_d = arb_idx;
                    state_d  = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                cand_d = rc_valid_ports_i;
                if (rc_valid_ports_i == '0) begin
                    unroutable_d = 1'b1;
                    rr_ptr_d     = next_requester(gnt_id_q);
                    state_d      = ST_IDLE;
                end else begin
                    sel_idx_d = sel_pick;
                    for (int p = 0; p < NumberOfPorts; p++) begin
                        port_d[p] = (sel_pick == PortIdxWidth'(p));
                    end
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready_i) begin
                    rr_ptr_d  = next_requester(gnt_id_q);
                    sel_ptr_d = next_port(sel_idx_q);
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            sel_ptr_q    <= '0;
            gnt_id_q     <= '0;
            x_dst_q      <= '0;
            y_dst_q      <= '0;
            cand_q       <= '0;
            port_q       <= '0;
            sel_idx_q    <= '0;
            unroutable_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            sel_ptr_q    <= sel_ptr_d;
            gnt_id_q     <= gnt_id_d;
            x_dst_q      <= x_dst_d;
            y_dst_q      <= y_dst_d;
            cand_q       <= cand_d;
            port_q       <= port_d;
            sel_idx_q    <= sel_idx_d;
            unroutable_q <= unroutable_d;
        end
    end

    assign rc_x_dst_o        = x_dst_q;
    assign rc_y_dst_o        = y_dst_q;
    assign resp_valid_o      = (state_q == ST_RESP);
    assign resp_req_id_o     = gnt_id_q;
    assign resp_port_o       = port_q;
    assign resp_candidates_o = cand_q;
    assign unroutable_o      = unroutable_q;

endmodule

// File: tb/tb_lbdr_route_compute_scheduler.sv
// Bench for lbdr_route_compute_scheduler: a transaction-level model plus directed and random stimulus,
// with a small LBDR candidate table standing in for the shared route unit (router at (1,1)).
module tb_lbdr_route_compute_scheduler;

    localparam int NR = 5;
    localparam int NP = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] req_valid;
    logic [9:0] req_x;
    logic [9:0] req_y;
    wire  [4:0] req_ready;
    wire  [1:0] rc_x;
    wire  [1:0] rc_y;
    logic [4:0] rc_ports;
    logic [4:0] port_avail;
    wire        resp_valid;
    logic       resp_ready;
    wire  [2:0] resp_id;
    wire  [4:0] resp_port;
    wire  [4:0] resp_cands;
    wire        unr;

    logic [4:0] cand_tbl [16];

    int n_cmp = 0;
    int n_bad = 0;

    // Port indices: 0 Local, 1 North, 2 East, 3 West, 4 South
    assign rc_ports = cand_tbl[{rc_x, rc_y}];

    always #5 clk = ~clk;

    lbdr_route_compute_scheduler dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_x_dst_i(req_x), .req_y_dst_i(req_y),
        .req_ready_o(req_ready), .rc_x_dst_o(rc_x), .rc_y_dst_o(rc_y),
        .rc_valid_ports_i(rc_ports), .port_avail_i(port_avail),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_req_id_o(resp_id), .resp_port_o(resp_port),
        .resp_candidates_o(resp_cands), .unroutable_o(unr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit bitat(input logic [31:0] v, input int i);
        return ((v >> i) & 32'd1) != 32'd0;
    endfunction

    function automatic logic [4:0] lbdr(input int x, input int y);
        logic [4:0] v;
        v = 5'b00000;
        if (x > 1) v = v | 5'b00100;
        if (x < 1) v = v | 5'b01000;
        if (y > 1) v = v | 5'b00010;
        if (y < 1) v = v | 5'b10000;
        if (v == 5'b00000) v = 5'b00001;
        return v;
    endfunction

    function automatic int oh_idx(input logic [4:0] v);
        for (int k = 0; k < NR; k++) if (bitat(32'(v), k)) return k;
        return -1;
    endfunction

    // Reference model: one outstanding transaction, tracked by its age since grant.
    bit         m_busy;
    int         m_age, m_id, m_x, m_y, m_rr, m_sel, m_pick;
    logic [4:0] m_cands, m_port;
    bit         m_unr;

    initial begin : model_proc
        int         w, idx;
        logic [4:0] c, elig, exp_ready;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_busy = 0; m_age = 0; m_rr = 0; m_sel = 0; m_unr = 0;
                check("rst_ready", 32'(req_ready), 32'd0);
                check("rst_resp_valid", 32'(resp_valid), 32'd0);
                check("rst_unroutable", 32'(unr), 32'd0);
                check("rst_rc_dst", 32'({rc_x, rc_y}), 32'd0);
                check("rst_resp_port", 32'(resp_port), 32'd0);
                check("rst_resp_id", 32'(resp_id), 32'd0);
                check("rst_resp_cands", 32'(resp_cands), 32'd0);
            end else begin
                w = -1;
                if (!m_busy) begin
                    for (int k = 0; k < NR; k++) begin
                        idx = (m_rr + k) % NR;
                        if (w < 0 && bitat(32'(req_valid), idx)) w = idx;
                    end
                end
                exp_ready = (w >= 0) ? 5'(1 << w) : 5'd0;
                check("req_ready", 32'(req_ready), 32'(exp_ready));
                check("resp_valid", 32'(resp_valid), 32'(m_busy && m_age >= 2));
                check("unroutable", 32'(unr), 32'(m_unr));
                if (m_busy) begin
                    check("rc_x_dst", 32'(rc_x), m_x);
                    check("rc_y_dst", 32'(rc_y), m_y);
                end
                if (m_busy && m_age >= 2) begin
                    check("resp_id", 32'(resp_id), m_id);
                    check("resp_port", 32'(resp_port), 32'(m_port));
                    check("resp_cands", 32'(resp_cands), 32'(m_cands));
                end
                if (!m_busy) begin
                    if (w >= 0) begin
                        m_busy = 1; m_age = 1; m_id = w;
                        m_x = int'((32'(req_x) >> (2 * w)) & 32'd3);
                        m_y = int'((32'(req_y) >> (2 * w)) & 32'd3);
                    end
                end else if (m_age == 1) begin
                    c = cand_tbl[4 * m_x + m_y];
                    m_cands = c;
                    if (c == 5'd0) begin
                        m_unr = 1; m_busy = 0; m_rr = (m_id + 1) % NR;
                    end else begin
                        elig = c & port_avail;
                        if (elig == 5'd0) elig = c;
                        m_pick = -1;
                        for (int k = 0; k < NP; k++) begin
                            idx = (m_sel + k) % NP;
                            if (m_pick < 0 && bitat(32'(elig), idx)) m_pick = idx;
                        end
                        m_port = 5'(1 << m_pick);
                        m_age = 2;
                    end
                end else if (resp_ready) begin
                    m_busy = 0; m_rr = (m_id + 1) % NR; m_sel = (m_pick + 1) % NP;
                end
            end
        end
    end

    logic [4:0] last_ready, last_port;
    logic       last_resp_valid, last_unr;
    logic [2:0] last_id;
    logic [1:0] last_rc_x;

    // One cycle: sample outputs mid-cycle, then drop any granted requests after the edge.
    task automatic step();
        @(negedge clk);
        last_ready = req_ready; last_resp_valid = resp_valid; last_port = resp_port;
        last_id = resp_id; last_unr = unr; last_rc_x = rc_x;
        @(posedge clk);
        #1;
        req_valid = req_valid & ~last_ready;
    endtask

    task automatic raise(input int r, input int x, input int y);
        req_x = (req_x & ~(10'd3 << (2 * r))) | (10'(x) << (2 * r));
        req_y = (req_y & ~(10'd3 << (2 * r))) | (10'(y) << (2 * r));
        req_valid = req_valid | 5'(1 << r);
    endtask

    initial begin : stim
        int g[$];
        int exp3[4];
        bit re, found;
        exp3 = '{0, 1, 3, 0};
        rst_n = 0; req_valid = 0; req_x = 0; req_y = 0; port_avail = '1; resp_ready = 0;
        for (int i = 0; i < 16; i++) cand_tbl[i] = lbdr(i / 4, i % 4);
        repeat (3) @(posedge clk);
        #1 rst_n = 1;

        repeat (10) step();
        check("idle_ready", 32'(last_ready), 32'd0);
        check("idle_resp_valid", 32'(last_resp_valid), 32'd0);

        // Single request to the east: grant at T, result at T+2
        resp_ready = 1;
        raise(2, 3, 1);
        step(); check("t2_ready", 32'(last_ready), 32'b00100);
        step(); check("t2_not_yet", 32'(last_resp_valid), 32'd0);
        step(); check("t2_valid", 32'(last_resp_valid), 32'd1);
        check("t2_port", 32'(last_port), 32'b00100);
        check("t2_id", 32'(last_id), 32'd2);
        step();

        rst_n = 0; req_valid = 0;
        step(); step();
        rst_n = 1;

        // Round-robin order with wrap
        raise(0, 3, 1); raise(1, 1, 3); raise(3, 0, 1);
        re = 0;
        for (int t = 0; t < 30 && g.size() < 4; t++) begin
            step();
            if (last_ready != 5'd0) g.push_back(oh_idx(last_ready));
            if (!re && g.size() == 1) begin re = 1; raise(0, 3, 1); end
        end
        check("t3_grants", g.size(), 32'd4);
        for (int k = 0; k < g.size() && k < 4; k++) check("t3_order", g[k], exp3[k]);
        repeat (3) step();

        // N|E with E out of credit
        port_avail = 5'b11011;
        raise(4, 2, 2);
        step(); step(); step();
        check("t4_valid", 32'(last_resp_valid), 32'd1);
        check("t4_port", 32'(last_port), 32'b00010);
        step();

        // N|E with neither credited: rotation pick, held while allocator stalls
        port_avail = 5'b11001; resp_ready = 0;
        raise(4, 2, 2);
        step();
        raise(0, 0, 0);
        step(); step();
        check("t5_valid", 32'(last_resp_valid), 32'd1);
        check("t5_port", 32'(last_port), 32'b00100);
        repeat (8) begin
            step();
            check("t5_hold_valid", 32'(last_resp_valid), 32'd1);
            check("t5_hold_port", 32'(last_port), 32'b00100);
            check("t5_hold_ready", 32'(last_ready), 32'd0);
            check("t5_hold_rc_x", 32'(last_rc_x), 32'd2);
        end
        resp_ready = 1;
        step();
        step(); check("t5_next_grant", 32'(last_ready), 32'b00001);
        repeat (3) step();

        // No candidates: sticky flag, request dropped, next one served
        port_avail = '1;
        cand_tbl[15] = 5'd0;
        raise(1, 3, 3);
        step(); step(); step();
        check("t6_unroutable", 32'(last_unr), 32'd1);
        check("t6_no_resp", 32'(last_resp_valid), 32'd0);
        raise(2, 3, 1);
        step(); check("t6_next_ready", 32'(last_ready), 32'b00100);
        step(); step();
        check("t6_next_valid", 32'(last_resp_valid), 32'd1);
        check("t6_sticky", 32'(last_unr), 32'd1);
        step();

        // Reset in the middle of RESP
        resp_ready = 0;
        raise(3, 0, 1);
        found = 0;
        for (int t = 0; t < 8 && !found; t++) begin
            step();
            if (last_resp_valid) found = 1;
        end
        check("t7_reached_resp", 32'(found), 32'd1);
        rst_n = 0; req_valid = 0;
        step();
        check("t7_rst_valid", 32'(last_resp_valid), 32'd0);
        check("t7_rst_unroutable", 32'(last_unr), 32'd0);
        rst_n = 1;
        repeat (2) step();
        check("t7_after_rst", 32'(last_resp_valid), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 16; i++)
            if ($urandom_range(0, 3) == 0) cand_tbl[i] = 5'($urandom_range(0, 31));
        repeat (400) begin
            step();
            resp_ready = ($urandom_range(0, 3) != 0);
            port_avail = 5'($urandom_range(0, 31));
            for (int r = 0; r < NR; r++) begin
                if (!bitat(32'(req_valid), r)) begin
                    if ($urandom_range(0, 2) == 0)
                        raise(r, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
                end else if ($urandom_range(0, 19) == 0) begin
                    req_valid = req_valid & ~5'(1 << r);
                end
            end
        end
        resp_ready = 1; req_valid = 0;
        repeat (5) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
